uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial receiver that pairs with the existing UART transmitter. Samples the asynchronous serial_in line and recovers 8N1 frames, LSB first, at BAUD_RATE. Each recovered byte is presented to the CPU-side peripheral logic through a one-entry valid/ready holding register. Sticky framing and overrun error flags are provided.

Parameters:
BAUD_RATE, 115200, serial bit rate in bits/s.
CLOCK_SPEED, 100_000_000, clk frequency in Hz.
TICKS_PER_BIT, CLOCK_SPEED / BAUD_RATE, derived, not overridden; must be >= 4. Bit counter width is $clog2(TICKS_PER_BIT).

Ports:
clk  input  1  system clock.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
serial_in  input  1  asynchronous serial line; idle high.
rx_data  output  8  received byte; stable while rx_valid=1.
rx_valid  output  1  holding register full.
rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready at a clk edge.
framing_error  output  1  sticky; a stop bit was sampled low.
overrun  output  1  sticky; a byte was lost because the holding register was full.
parity_error  output  1  sticky; parity mismatch. Tied 0 without the optional feature.
error_clear  input  1  synchronous clear of all sticky flags.

Behaviour:
- Reset (rst=0) is asynchronous and takes effect immediately: rx_data=0, rx_valid=0, all error flags=0, FSM in IDLE, counters=0, and both synchronizer flops=1.
- serial_in passes through a 2-flop synchronizer; the FSM sees only the synchronized value rx_s.
- IDLE: when rx_s=0, go to START and clear tick_cnt.
- START: count to TICKS_PER_BIT/2-1, then sample at mid-bit.
  - rx_s=0: go to DATA, clear tick_cnt and bit_idx.
  - rx_s=1: false start; return to IDLE silently.
- DATA: at tick_cnt=TICKS_PER_BIT-1, sample rx_s into shift[bit_idx] and clear tick_cnt. After bit_idx=7, go to STOP (or PARITY when the feature is on).
- STOP: at tick_cnt=TICKS_PER_BIT-1, sample rx_s.
  - rx_s=1: deliver the byte and go to IDLE.
  - rx_s=0: set framing_error, discard the byte, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s=1, then go to IDLE. A held-low break therefore yields exactly one framing error and no bytes.
- Delivery, evaluated at the same edge as the stop sample:
  - Register empty, or consumed in that same cycle: load rx_data and set rx_valid=1. No overrun in the same-cycle consume case.
  - Register full and not consumed: keep the old rx_data, discard the new byte, set overrun.
- A consume (rx_valid && rx_ready) with no simultaneous delivery clears rx_valid next cycle.
- Latency: rx_valid rises 9.5*TICKS_PER_BIT + 3 clk cycles (±1) after the serial_in falling edge.
- error_clear takes priority over a flag set in the same cycle: the flag ends up 0.
- Receive is never stalled by rx_ready; the FSM runs freely.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one even-parity bit at mid-bit.
  - On mismatch, parity_error is set, but the byte is still delivered normally.
  - Frame length is 11 bits; latency grows by TICKS_PER_BIT.
- Undefined:
  - No PARITY state exists; frames are 8N1.
  - parity_error is constant 0.

Test Plan:
Use CLOCK_SPEED=1_600_000 and BAUD_RATE=100_000 (TICKS_PER_BIT=16) for all scenarios.
1. Frame 0xA5 with rx_ready=1 -> rx_valid high for 1 cycle, rx_data=0xA5, 155±1 cycles after the start edge, all flags 0.
2. serial_in low for 4 clk cycles, then high -> no rx_valid, FSM back in IDLE. A following 0x3C frame is received correctly.
3. Frame 0x3C with the stop bit driven 0, line held low for 40 cycles -> framing_error=1, rx_valid stays 0. Next frame 0x55 is received.
4. Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11, rx_valid=1, overrun=1. A 1-cycle error_clear pulse -> overrun=0 with rx_data still 0x11.
5. rst pulled low during bit 3 of a frame -> all outputs at reset values in the same cycle. After release and line idle, frame 0x7E is received correctly.
6. With UART_RX_PARITY_EN defined, 0x0F sent with parity bit 1 -> rx_data=0x0F, rx_valid=1, parity_error=1. The same byte with parity bit 0 -> parity_error stays 0.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (8E1) and a live parity_error flag.
module uart_rx #(
    parameter int BAUD_RATE   = 115200,
    parameter int CLOCK_SPEED = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error,
    input  logic       error_clear
);

    localparam int TICKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
    localparam int CNT_W         = $clog2(TICKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(TICKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             pe_q, pe_d;
`endif

    assign rx_s = sync2_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        ov_d    = ov_q;
`ifdef UART_RX_PARITY_EN
        pe_d    = pe_q;
`endif
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick_q == HALF_M1) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q == FULL_M1) begin
                    tick_d         = '0;
                    shift_d[bit_q] = rx_s;
                    bit_d          = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick_q == FULL_M1) begin
                    tick_d  = '0;
                    state_d = STOP;
                    if (^{shift_q, rx_s}) begin
                        pe_d = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick_q == FULL_M1) begin
                    tick_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        // A same-cycle consume frees the slot, so it is not an overrun.
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                tick_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = IDLE;
            end
        endcase
        if (error_clear) begin
            fe_d = 1'b0;
            ov_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
            pe_q    <= pe_d;
`endif
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = pe_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner sequences, a vector table and random frames vs a frame-level model.
module tb_uart_rx;

    localparam int TPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int EXP_LAT = 155 + TPB;
`else
    localparam int EXP_LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       rx_ready;
    logic       error_clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic       parity_error;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int start_cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .BAUD_RATE  (100_000),
        .CLOCK_SPEED(1_600_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .framing_error(framing_error),
        .overrun      (overrun),
        .parity_error (parity_error),
        .error_clear  (error_clear)
    );

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       ready;
        logic       clr;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_fe;
        logic       e_ov;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n clock edges and land 1 ns after the last one (drive/sample point).
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        serial_in = v;
        tick(TPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input int hold_low);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`endif
        send_bit(stop);
        if (hold_low > 0) tick(hold_low);
        serial_in = 1'b1;
    endtask

    task automatic clear_pulse();
        error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    vec_t       tbl[7];
    logic [7:0] m_data;
    logic       m_valid, m_fe, m_ov;

    initial begin
        int         lat;
        int         w;
        logic [7:0] d_rise;
        logic [7:0] b;
        logic       stop, rdy, clr;

        rst = 1'b0; serial_in = 1'b1; rx_ready = 1'b0; error_clear = 1'b0;
        tick(3);
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_fe", framing_error, 1'b0);
        check("reset_ov", overrun, 1'b0);
        check("reset_pe", parity_error, 1'b0);
        rst = 1'b1;
        tick(5);

        // Single frame, consumer always ready: latency and 1-cycle valid pulse.
        rx_ready = 1'b1;
        lat = -1; w = 0; d_rise = 8'h00;
        fork
            send_frame(8'hA5, 1'b1, ^8'hA5, 0);
            begin
                for (int k = 0; k < 400 && lat < 0; k++) begin
                    @(negedge clk);
                    if (rx_valid) begin
                        lat = cyc - start_cyc;
                        d_rise = rx_data;
                    end
                end
                if (lat >= 0) begin
                    w = 1;
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        if (rx_valid) w++;
                        else break;
                    end
                end
            end
        join
        vectors++;
        if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
            miscompares++;
            $display("FAIL latency: got %0d expected %0d+-1", lat, EXP_LAT);
        end
        check("t1_data", d_rise, 8'hA5);
        check("t1_pulse_width", 8'(w), 8'd1);
        tick(4);
        check("t1_fe", framing_error, 1'b0);
        check("t1_ov", overrun, 1'b0);
        check("t1_pe", parity_error, 1'b0);
        rx_ready = 1'b0;

        // False start: 4-cycle glitch must not produce a byte.
        serial_in = 1'b0;
        tick(4);
        serial_in = 1'b1;
        tick(40);
        check("t2_glitch_valid", rx_valid, 1'b0);
        send_frame(8'h3C, 1'b1, ^8'h3C, 0);
        tick(4);
        check("t2_data", rx_data, 8'h3C);
        check("t2_valid", rx_valid, 1'b1);
        consume();
        check("t2_consumed", rx_valid, 1'b0);

        // Break: stop bit low and line held low.
        send_frame(8'h3C, 1'b0, ^8'h3C, 40);
        tick(8);
        check("t3_fe", framing_error, 1'b1);
        check("t3_valid", rx_valid, 1'b0);
        send_frame(8'h55, 1'b1, ^8'h55, 0);
        tick(4);
        check("t3_data", rx_data, 8'h55);
        check("t3_valid2", rx_valid, 1'b1);
        check("t3_fe_sticky", framing_error, 1'b1);
        consume();
        clear_pulse();
        check("t3_fe_cleared", framing_error, 1'b0);

        // Overrun: two back-to-back frames, nobody reading.
        send_frame(8'h11, 1'b1, ^8'h11, 0);
        send_frame(8'h22, 1'b1, ^8'h22, 0);
        tick(4);
        check("t4_data", rx_data, 8'h11);
        check("t4_valid", rx_valid, 1'b1);
        check("t4_ov", overrun, 1'b1);
        clear_pulse();
        check("t4_ov_cleared", overrun, 1'b0);
        check("t4_data_kept", rx_data, 8'h11);
        check("t4_valid_kept", rx_valid, 1'b1);

        // Asynchronous reset during data bit 3.
        b = 8'h7E;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        serial_in = b[3];
        tick(5);
        check("t5_pre_valid", rx_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_data", rx_data, 8'h00);
        check("t5_rst_valid", rx_valid, 1'b0);
        check("t5_rst_fe", framing_error, 1'b0);
        check("t5_rst_ov", overrun, 1'b0);
        serial_in = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(5);
        send_frame(8'h7E, 1'b1, ^8'h7E, 0);
        tick(4);
        check("t5_data", rx_data, 8'h7E);
        check("t5_valid", rx_valid, 1'b1);
        check("t5_fe", framing_error, 1'b0);
        consume();

        // Table of frames applied in sequence; state carries from row to row.
        tbl[0] = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h22, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        for (int r = 0; r < 7; r++) begin
            if (tbl[r].clr) clear_pulse();
            rx_ready = tbl[r].ready;
            tick(1);
            send_frame(tbl[r].b, tbl[r].stop, ^tbl[r].b, 0);
            tick(6);
            check($sformatf("tbl%0d_data", r), rx_data, tbl[r].e_data);
            check($sformatf("tbl%0d_valid", r), rx_valid, tbl[r].e_valid);
            check($sformatf("tbl%0d_fe", r), framing_error, tbl[r].e_fe);
            check($sformatf("tbl%0d_ov", r), overrun, tbl[r].e_ov);
        end
        consume();
        clear_pulse();

        // Random frames against a frame-level model of the holding register and flags.
        m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        for (int n = 0; n < 25; n++) begin
            b    = 8'($urandom);
            rdy  = 1'($urandom % 2);
            clr  = ($urandom % 6) == 0;
            stop = ($urandom % 8) != 0;
            if (clr) begin
                clear_pulse();
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            rx_ready = rdy;
            if (rdy) m_valid = 1'b0;
            tick(1);
            send_frame(b, stop, ^b, 0);
            tick(6);
            if (stop) begin
                if (!m_valid) begin
                    m_data  = b;
                    m_valid = 1'b1;
                end else begin
                    m_ov = 1'b1;
                end
            end else begin
                m_fe = 1'b1;
            end
            if (rdy) m_valid = 1'b0;
            check($sformatf("rnd%0d_data", n), rx_data, m_data);
            check($sformatf("rnd%0d_valid", n), rx_valid, m_valid);
            check($sformatf("rnd%0d_fe", n), framing_error, m_fe);
            check($sformatf("rnd%0d_ov", n), overrun, m_ov);
            check($sformatf("rnd%0d_pe", n), parity_error, 1'b0);
        end
        rx_ready = 1'b0;

`ifdef UART_RX_PARITY_EN
        consume();
        clear_pulse();
        send_frame(8'h0F, 1'b1, 1'b1, 0);
        tick(4);
        check("t6_bad_data", rx_data, 8'h0F);
        check("t6_bad_valid", rx_valid, 1'b1);
        check("t6_bad_pe", parity_error, 1'b1);
        consume();
        clear_pulse();
        check("t6_pe_cleared", parity_error, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 0);
        tick(4);
        check("t6_good_data", rx_data, 8'h0F);
        check("t6_good_valid", rx_valid, 1'b1);
        check("t6_good_pe", parity_error, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
